// File: rtl/if_stage_if.sv
// Bundles the fetch-stage signals: the hazard/branch inputs, the instruction-memory port,
// the IF/ID register outputs and the performance counters.
interface if_stage_if;
   logic        freeze;
   logic        B_taken;
   logic [31:0] br_addr;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;

   modport master (
      input  freeze, B_taken, br_addr, imem_rdata,
      output imem_addr, if_id_pc, if_id_instr, if_id_valid, perf_fetch_cnt, perf_flush_cnt
   );

   modport slave (
      output freeze, B_taken, br_addr, imem_rdata,
      input  imem_addr, if_id_pc, if_id_instr, if_id_valid, perf_fetch_cnt, perf_flush_cnt
   );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register plus IF/ID pipeline register.
// Define IF_STAGE_PERF_CNT_EN to build the fetch/flush performance counters.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   if_stage_if.master  bus
);
   logic [31:0] pc_p0;
   logic [31:0] pc_plus4;
   logic [31:0] instr_p1;
   logic [31:0] pc_p1;
   logic        vld_p1;
   logic        load_p1;

   assign pc_plus4      = pc_p0 + 32'd4;
   assign load_p1       = !bus.B_taken && !bus.freeze;
   assign bus.imem_addr = pc_p0;

   // PC stage: branch redirect beats freeze; the target is forced word-aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_p0 <= RESET_PC;
      end else if (bus.B_taken) begin
         pc_p0 <= {bus.br_addr[31:2], 2'b00};
      end else if (!bus.freeze) begin
         pc_p0 <= pc_plus4;
      end
   end

   // IF/ID stage: a taken branch discards the word fetched this cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_p1    <= 32'd0;
         instr_p1 <= NOP_INSTR;
         vld_p1   <= 1'b0;
      end else if (bus.B_taken) begin
         pc_p1    <= 32'd0;
         instr_p1 <= NOP_INSTR;
         vld_p1   <= 1'b0;
      end else if (!bus.freeze) begin
         pc_p1    <= pc_plus4;
         instr_p1 <= bus.imem_rdata;
         vld_p1   <= 1'b1;
      end
   end

   assign bus.if_id_pc    = pc_p1;
   assign bus.if_id_instr = instr_p1;
   assign bus.if_id_valid = vld_p1;

`ifdef IF_STAGE_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (load_p1) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (bus.B_taken) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end

   assign bus.perf_fetch_cnt = fetch_cnt;
   assign bus.perf_flush_cnt = flush_cnt;
`else
   logic unused_load;
   assign unused_load        = load_p1;
   assign bus.perf_fetch_cnt = 32'd0;
   assign bus.perf_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a driver applies directed then random stimulus and queues
// the expected post-edge state; a monitor pops and compares after each rising edge.
module tb_if_stage;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'hDEAD_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ipc;
      logic [31:0] instr;
      logic        vld;
      logic [31:0] fcnt;
      logic [31:0] flcnt;
   } exp_t;

   logic clk;
   logic rst;
   if_stage_if bus();

   exp_t exp_q[$];
   int   checks;
   int   errors;

   // reference state of the fetch stage, updated per cycle from the behaviour rules
   logic [31:0] m_pc, m_ipc, m_instr, m_fcnt, m_flcnt;
   logic        m_vld;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign bus.imem_rdata = mem_word(bus.imem_addr);

   if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step(input logic r, input logic frz, input logic bt, input logic [31:0] ba);
      exp_t e;
      @(negedge clk);
      rst         = r;
      bus.freeze  = frz;
      bus.B_taken = bt;
      bus.br_addr = ba;
      if (r) begin
         m_pc = RST_PC; m_ipc = 32'd0; m_instr = NOP; m_vld = 1'b0;
         m_fcnt = 32'd0; m_flcnt = 32'd0;
      end else if (bt) begin
         m_pc = ba & 32'hFFFF_FFFC; m_ipc = 32'd0; m_instr = NOP; m_vld = 1'b0;
         m_flcnt = m_flcnt + 32'd1;
      end else if (!frz) begin
         m_ipc   = m_pc + 32'd4;
         m_instr = mem_word(m_pc);
         m_vld   = 1'b1;
         m_pc    = m_pc + 32'd4;
         m_fcnt  = m_fcnt + 32'd1;
      end
      e.pc = m_pc; e.ipc = m_ipc; e.instr = m_instr; e.vld = m_vld;
`ifdef IF_STAGE_PERF_CNT_EN
      e.fcnt = m_fcnt; e.flcnt = m_flcnt;
`else
      e.fcnt = 32'd0; e.flcnt = 32'd0;
`endif
      exp_q.push_back(e);
   endtask

   // monitor: compares every queued expectation one delta-safe step after the edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("imem_addr", bus.imem_addr, e.pc);
         chk("if_id_pc", bus.if_id_pc, e.ipc);
         chk("if_id_instr", bus.if_id_instr, e.instr);
         chk("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.vld});
         chk("perf_fetch_cnt", bus.perf_fetch_cnt, e.fcnt);
         chk("perf_flush_cnt", bus.perf_flush_cnt, e.flcnt);
      end
   end

   initial begin
      logic        r, f, b;
      logic [31:0] a;
      checks = 0; errors = 0;
      rst = 1'b1; bus.freeze = 1'b0; bus.B_taken = 1'b0; bus.br_addr = 32'd0;
      m_pc = RST_PC; m_ipc = 0; m_instr = NOP; m_vld = 0; m_fcnt = 0; m_flcnt = 0;

      step(1, 0, 0, 0); step(1, 0, 0, 0);
      step(0, 0, 0, 0); step(0, 0, 0, 0);                     // pc 4, 8
      step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);   // hold at 8
      step(0, 0, 0, 0); step(0, 0, 0, 0);                     // pc 12, 16
      step(0, 0, 1, 32'h0000_0043);                           // redirect to 0x40
      step(0, 0, 0, 0);
      step(0, 1, 1, 32'h0000_0100);                           // branch beats freeze
      step(0, 0, 0, 0);
      step(0, 0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 0); step(0, 0, 0, 0);                     // wrap to 0
      step(0, 1, 1, 32'h0000_0200); step(0, 0, 1, 32'h0000_0300); // back-to-back
      step(0, 1, 0, 0); step(1, 1, 0, 0);                     // reset during freeze
      step(0, 0, 0, 0);

      for (int i = 0; i < 500; i++) begin
         r = ($urandom_range(0, 99) < 3);
         f = ($urandom_range(0, 99) < 25);
         b = ($urandom_range(0, 99) < 15);
         a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF9 : $urandom;
         step(r, f, b, a);
      end

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address. Registers the fetched word plus PC+4 into the IF/ID pipeline register.
- Consumes the branch decision (`B_taken`) and branch target produced by the EXE-stage condition check and the address adder.
- Consumes `freeze` from the hazard-detection unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  stall request from hazard unit; holds PC and IF/ID.
- B_taken  input  1  branch-taken from EXE condition check; redirects PC and flushes IF/ID.
- br_addr  input  32  branch target byte address from EXE.
- imem_addr  output  32  instruction-memory byte address (combinational copy of PC).
- imem_rdata  input  32  instruction word returned combinationally by instruction memory for imem_addr.
- if_id_pc  output  32  registered PC+4 of the instruction in IF/ID.
- if_id_instr  output  32  registered instruction word.
- if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- perf_fetch_cnt  output  32  fetched-instruction counter (see Optional Feature).
- perf_flush_cnt  output  32  flush counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at rising edge) overrides everything, including mid-stall or mid-branch:
  - pc <= RESET_PC
  - if_id_pc <= 0, if_id_instr <= NOP_INSTR, if_id_valid <= 0
  - perf counters <= 0
- imem_addr = pc, combinational. No extra fetch latency; instruction memory is asynchronous-read.
- PC update priority at each rising edge (rst=0):
  1. B_taken=1: pc <= {br_addr[31:2],2'b00}. Low two bits are always forced to zero.
  2. else freeze=1: pc holds.
  3. else pc <= pc + 4, 32-bit modulo. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- IF/ID update priority at each rising edge (rst=0):
  1. B_taken=1 (flush): if_id_instr <= NOP_INSTR, if_id_pc <= 0, if_id_valid <= 0. The word fetched this cycle is discarded.
  2. else freeze=1: all IF/ID fields hold.
  3. else: if_id_instr <= imem_rdata, if_id_pc <= pc + 4 (same wrap rule), if_id_valid <= 1.
- Simultaneous B_taken and freeze: branch wins. PC redirects and IF/ID flushes. freeze is ignored that cycle.
- B_taken is sampled only at the clock edge. Combinational glitches between edges have no effect.
- Back-to-back B_taken on consecutive cycles: each cycle redirects to that cycle's br_addr and flushes again.
- Latency:
  - Instruction at pc appears on if_id_instr one cycle after it is addressed, absent freeze/flush.
  - First valid IF/ID entry appears one cycle after rst deasserts.
- No combinational path from any input to if_id_* outputs. Only imem_addr is combinational, and only from pc.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments by 1 on every edge where IF/ID loads a valid instruction (rst=0, B_taken=0, freeze=0).
  - perf_flush_cnt increments by 1 on every edge with rst=0 and B_taken=1.
  - Both are 32-bit, wrap 32'hFFFF_FFFF to 0, and clear on rst.
- Not defined:
  - Both outputs are tied to constant 0.
  - No counter registers are synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset then run: rst high 2 cycles, then low, imem returns addr-derived words.
  - imem_addr sequence 0, 4, 8, 12.
  - First valid IF/ID appears one cycle after rst low with if_id_pc=4, if_id_instr=word@0.
- Freeze: freeze=1 for 3 cycles while pc=8.
  - imem_addr stays 8.
  - IF/ID holds pc=8/word@4 with valid=1.
  - On release, next IF/ID = pc 12 / word@8.
- Branch: B_taken=1, br_addr=32'h0000_0043 at pc=16.
  - Next pc=32'h0000_0040.
  - IF/ID = NOP_INSTR, valid=0, pc=0.
  - Following cycle IF/ID = word@0x40, pc 0x44.
- Branch+freeze same cycle: freeze=1, B_taken=1, br_addr=0x100.
  - pc=0x100 and IF/ID flushed (freeze ignored).
- Wrap and mid-operation reset:
  - Branch to 32'hFFFF_FFFC, run → pc becomes 0, if_id_pc=0.
  - Assert rst during freeze=1 → pc=RESET_PC, valid=0 next edge.
- With IF_STAGE_PERF_CNT_EN:
  - 5 normal fetches, 2 branches, 1 freeze cycle → perf_fetch_cnt=5, perf_flush_cnt=2.
  - rst clears both to 0.
  - Without the macro, both read 0 throughout.
